// File: rtl/pwm_demod.sv
// PWM receiver: synchronises pwm_in and reports high time and period per PWM cycle.
// Optional duty IIR smoothing is enabled by defining PWM_DEMOD_FILTER_EN.
module pwm_demod #(
    parameter int unsigned CNT_W        = 12,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned FILTER_SHIFT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] duty,
    output logic [CNT_W-1:0] period,
    output logic             sample_valid,
    output logic             timeout
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    if (SYNC_STAGES < 2 || FILTER_SHIFT > CNT_W) begin : g_bad_param
        $error("pwm_demod: SYNC_STAGES must be >= 2 and FILTER_SHIFT <= CNT_W");
    end

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_in;
    logic                   s_prev;
    logic                   rise;
    logic                   fall;

    state_t                 state_q;
    state_t                 state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic [CNT_W-1:0]       cnt_inc;
    logic [CNT_W-1:0]       hi_cnt_q;
    logic [CNT_W-1:0]       hi_cnt_d;
    logic [CNT_W-1:0]       raw_duty;
    logic [CNT_W-1:0]       raw_period;
    logic [CNT_W-1:0]       duty_d;
    logic                   emit;
    logic                   tmo_evt;
    logic                   timeout_d;

    // Input synchroniser plus one history flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            s_prev <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            s_prev <= s_in;
        end
    end

    assign s_in    = sync_q[SYNC_STAGES-1];
    assign rise    = s_in & ~s_prev;
    assign fall    = ~s_in & s_prev;
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    // Next-state, counters and sample generation
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_cnt_d   = hi_cnt_q;
        raw_duty   = hi_cnt_q;
        raw_period = cnt_q;
        emit       = 1'b0;
        tmo_evt    = 1'b0;
        timeout_d  = timeout;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = HIGH;
                    cnt_d   = CNT_ONE;
                end
            end
            HIGH: begin
                if (cnt_q == CNT_MAX && !rise) begin
                    tmo_evt = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                    if (fall) begin
                        hi_cnt_d = cnt_q;
                        state_d  = LOW;
                    end
                end
            end
            LOW: begin
                if (rise) begin
                    emit    = 1'b1;
                    cnt_d   = CNT_ONE;
                    state_d = HIGH;
                end else if (cnt_q == CNT_MAX) begin
                    tmo_evt = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
        // A stuck input reports 0% or 100% and drops back to waiting for an edge
        if (tmo_evt) begin
            emit       = 1'b1;
            raw_duty   = s_in ? CNT_MAX : '0;
            raw_period = CNT_MAX;
            cnt_d      = '0;
            state_d    = IDLE;
        end
        timeout_d = tmo_evt | (timeout & ~(state_q == IDLE && rise));
    end

`ifdef PWM_DEMOD_FILTER_EN
    localparam int unsigned ACC_W = CNT_W + FILTER_SHIFT;

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic             first_q;
    logic             first_d;

    // First-order IIR on duty; first sample after reset/timeout seeds the accumulator
    always_comb begin
        acc_d   = acc_q;
        first_d = first_q;
        duty_d  = raw_duty;
        if (emit) begin
            if (tmo_evt) begin
                first_d = 1'b1;
            end else begin
                if (first_q) begin
                    acc_d = ACC_W'(raw_duty) << FILTER_SHIFT;
                end else begin
                    acc_d = acc_q + ACC_W'(raw_duty) - (acc_q >> FILTER_SHIFT);
                end
                first_d = 1'b0;
                duty_d  = CNT_W'(acc_d >> FILTER_SHIFT);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            first_q <= 1'b1;
        end else begin
            acc_q   <= acc_d;
            first_q <= first_d;
        end
    end
`else
    assign duty_d = raw_duty;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            hi_cnt_q     <= '0;
            duty         <= '0;
            period       <= '0;
            sample_valid <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hi_cnt_q     <= hi_cnt_d;
            sample_valid <= emit;
            timeout      <= timeout_d;
            if (emit) begin
                duty   <= duty_d;
                period <= raw_period;
            end
        end
    end

endmodule

// File: tb/tb_pwm_demod.sv
// Directed bench for pwm_demod: a 12-bit instance for normal waveforms and a
// 6-bit instance for saturation/timeout behaviour.
`timescale 1ns/1ps
module tb_pwm_demod;
    localparam int unsigned W  = 12;
    localparam int unsigned W6 = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          pwm;
    logic          pwm6;
    logic [W-1:0]  duty;
    logic [W-1:0]  period;
    logic          sv;
    logic          tmo;
    logic [W6-1:0] duty6;
    logic [W6-1:0] period6;
    logic          sv6;
    logic          tmo6;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;
    int rise_cyc  = 0;
    int base;

    logic [31:0] q_duty[$];
    logic [31:0] q_period[$];
    logic [31:0] q_cyc[$];
    logic [31:0] q_lat[$];
    logic [31:0] q_tmo[$];
    int          n6 = 0;
    logic [31:0] l6_duty;
    logic [31:0] l6_period;
    logic [31:0] l6_tmo;

    pwm_demod #(.CNT_W(W), .SYNC_STAGES(2), .FILTER_SHIFT(3)) dut (
        .clk(clk), .rst(rst), .pwm_in(pwm),
        .duty(duty), .period(period), .sample_valid(sv), .timeout(tmo)
    );

    pwm_demod #(.CNT_W(W6), .SYNC_STAGES(2), .FILTER_SHIFT(3)) dut6 (
        .clk(clk), .rst(rst), .pwm_in(pwm6),
        .duty(duty6), .period(period6), .sample_valid(sv6), .timeout(tmo6)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe recorder, sampled mid-cycle
    always @(negedge clk) begin
        if (sv === 1'b1) begin
            q_duty.push_back(32'(duty));
            q_period.push_back(32'(period));
            q_cyc.push_back(32'(cyc));
            q_lat.push_back(32'(cyc - rise_cyc));
            q_tmo.push_back(32'(tmo));
        end
        if (sv6 === 1'b1) begin
            n6++;
            l6_duty   = 32'(duty6);
            l6_period = 32'(period6);
            l6_tmo    = 32'(tmo6);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int hi, input int lo);
        pwm      = 1'b1;
        rise_cyc = cyc;
        wait_cyc(hi);
        pwm = 1'b0;
        wait_cyc(lo);
    endtask

    task automatic pulse6(input int hi, input int lo);
        pwm6 = 1'b1;
        wait_cyc(hi);
        pwm6 = 1'b0;
        wait_cyc(lo);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(2);
        q_duty.delete();
        q_period.delete();
        q_cyc.delete();
        q_lat.delete();
        q_tmo.delete();
    endtask

    initial begin
        rst  = 1'b1;
        pwm  = 1'b0;
        pwm6 = 1'b0;

        // Reset held 3 cycles with the input toggling
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pwm  = ~pwm;
            pwm6 = ~pwm6;
            chk("rst_sv", 32'(sv), 32'd0);
        end
        chk("rst_duty", 32'(duty), 32'd0);
        chk("rst_period", 32'(period), 32'd0);
        chk("rst_timeout", 32'(tmo), 32'd0);
        chk("rst_sv6", 32'(sv6), 32'd0);
        pwm  = 1'b0;
        pwm6 = 1'b0;
        rst  = 1'b0;
        wait_cyc(6);
        chk("post_rst_no_strobe", 32'(q_duty.size()), 32'd0);

        // Steady 5 high / 11 low, 4 periods
        for (int p = 0; p < 4; p++) pulse(5, 11);
        wait_cyc(5);
        chk("steady_count", 32'(q_duty.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < q_duty.size()) begin
                chk($sformatf("steady_duty%0d", i), q_duty[i], 32'd5);
                chk($sformatf("steady_period%0d", i), q_period[i], 32'd16);
                chk($sformatf("steady_latency%0d", i), q_lat[i], 32'd3);
                chk($sformatf("steady_tmo%0d", i), q_tmo[i], 32'd0);
            end
        end

        // Reset in the middle of a measurement discards it
        pwm = 1'b1;
        wait_cyc(4);
        do_reset();
        pwm = 1'b0;
        wait_cyc(20);
        chk("midreset_no_strobe", 32'(q_duty.size()), 32'd0);
        do_reset();

        // Divider-scale waveform, edges offset 3 ns from the clock
        @(posedge clk);
        #3;
        for (int p = 0; p < 4; p++) begin
            pwm = 1'b1;
            repeat (374) @(posedge clk);
            #3 pwm = 1'b0;
            repeat (374) @(posedge clk);
            #3;
        end
        @(negedge clk);
        wait_cyc(5);
        chk("div_count", 32'(q_duty.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < q_duty.size()) begin
                chk($sformatf("div_duty%0d", i), q_duty[i], 32'd374);
                chk($sformatf("div_period%0d", i), q_period[i], 32'd748);
            end
            if (i > 0 && i < q_cyc.size())
                chk($sformatf("div_spacing%0d", i), q_cyc[i] - q_cyc[i-1], 32'd748);
        end
        do_reset();

        // Timeout on the 6-bit instance: input held high after a rise
        base = n6;
        pwm6 = 1'b1;
        wait_cyc(80);
        chk("tmo_count", 32'(n6 - base), 32'd1);
        chk("tmo_duty", l6_duty, 32'd63);
        chk("tmo_period", l6_period, 32'd63);
        chk("tmo_flag_strobe", l6_tmo, 32'd1);
        wait_cyc(80);
        chk("tmo_level_held", 32'(tmo6), 32'd1);
        chk("tmo_no_repeat", 32'(n6 - base), 32'd1);
        pwm6 = 1'b0;
        wait_cyc(5);
        pulse6(3, 5);
        chk("tmo_cleared", 32'(tmo6), 32'd0);
        chk("tmo_restart_no_strobe", 32'(n6 - base), 32'd1);
        pwm6 = 1'b1;
        wait_cyc(6);
        chk("tmo_next_count", 32'(n6 - base), 32'd2);
        chk("tmo_next_duty", l6_duty, 32'd3);
        chk("tmo_next_period", l6_period, 32'd8);
        chk("tmo_next_flag", l6_tmo, 32'd0);
        pwm6 = 1'b0;
        do_reset();

        // Rise exactly in the saturation cycle: period 63 on a 6-bit counter
        base = n6;
        for (int p = 0; p < 3; p++) pulse6(10, 53);
        chk("sat_count", 32'(n6 - base), 32'd2);
        chk("sat_duty", l6_duty, 32'd10);
        chk("sat_period", l6_period, 32'd63);
        chk("sat_flag", 32'(tmo6), 32'd0);
        do_reset();

        // Minimum 1-cycle high pulse with 7-cycle low
        base = n6;
        for (int p = 0; p < 4; p++) pulse6(1, 7);
        chk("min_count", 32'(n6 - base), 32'd3);
        chk("min_duty", l6_duty, 32'd1);
        chk("min_period", l6_period, 32'd8);
        chk("min_flag", l6_tmo, 32'd0);
        do_reset();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
